// File: rtl/memory_cycle_if.sv
// Data-memory bus between the MEM stage (master) and a variable-latency data memory (slave).
// req is held with stable we/addr/wdata/bmask until the memory returns ack; rdata is valid in the ack cycle.
interface memory_cycle_if;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_bmask;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_bmask,
        input  i_dmem_ack, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_bmask,
        output i_dmem_ack, i_dmem_rdata
    );
endinterface

// File: rtl/memory_cycle.sv
// MEM stage of the RV32I pipeline: issues loads/stores over the dmem req/ack bus and registers MEM/WB.
// Optional macro MEM_TIMEOUT_EN adds a BUSY-cycle watchdog that aborts after TIMEOUT_CYCLES without ack.
module memory_cycle #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_mem_valid,
    input  logic [31:0]   i_mem_inst,
    input  logic [31:0]   i_mem_pc_add4,
    input  logic [31:0]   i_mem_alu_data,
    input  logic [31:0]   i_mem_rs2_data,
    input  logic [1:0]    i_mem_wb_sel,
    input  logic          i_mem_rd_wren,
    output logic          o_mem_stall,
    output logic          o_mem_misalign,
    output logic          o_mem_fault,
    memory_cycle_if.master dmem,
    output logic          o_wb_valid,
    output logic [31:0]   o_wb_inst,
    output logic [31:0]   o_wb_pc_add4,
    output logic [31:0]   o_wb_alu_data,
    output logic [31:0]   o_wb_ld_data,
    output logic [1:0]    o_wb_wb_sel,
    output logic          o_wb_rd_wren,
    output logic [4:0]    o_mem_rd_addr,
    output logic          o_dbg_state
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_stall;
    logic        w_expire;

    logic [31:0] r_inst;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc_add4;
    logic [3:0]  r_bmask;
    logic        r_we;
    logic [1:0]  r_wb_sel;
    logic        r_rd_wren;

    logic        r_wb_valid;
    logic [31:0] r_wb_inst;
    logic [31:0] r_wb_pc_add4;
    logic [31:0] r_wb_alu_data;
    logic [31:0] r_wb_ld_data;
    logic [1:0]  r_wb_wb_sel;
    logic        r_wb_rd_wren;
    logic        r_misalign;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_misalign;
    logic [3:0]  w_st_bmask;
    logic [31:0] w_st_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    // Decode of the instruction currently in the EX/MEM slot.
    assign w_opcode   = i_mem_inst[6:0];
    assign w_funct3   = i_mem_inst[14:12];
    assign w_is_load  = (w_opcode == 7'b0000011) &&
                        (w_funct3 == 3'b000 || w_funct3 == 3'b001 || w_funct3 == 3'b010 ||
                         w_funct3 == 3'b100 || w_funct3 == 3'b101);
    assign w_is_store = (w_opcode == 7'b0100011) &&
                        (w_funct3 == 3'b000 || w_funct3 == 3'b001 || w_funct3 == 3'b010);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_misalign = ((w_funct3[1:0] == 2'b10) && (i_mem_alu_data[1:0] != 2'b00)) ||
                        ((w_funct3[1:0] == 2'b01) && i_mem_alu_data[0]);

    always_comb begin
        w_st_bmask = 4'b1111;
        w_st_wdata = 32'h0;
        if (w_is_store) begin
            case (w_funct3[1:0])
                2'b00: begin
                    w_st_bmask = 4'b0001 << i_mem_alu_data[1:0];
                    w_st_wdata = {4{i_mem_rs2_data[7:0]}};
                end
                2'b01: begin
                    w_st_bmask = i_mem_alu_data[1] ? 4'b1100 : 4'b0011;
                    w_st_wdata = {2{i_mem_rs2_data[15:0]}};
                end
                default: begin
                    w_st_bmask = 4'b1111;
                    w_st_wdata = i_mem_rs2_data;
                end
            endcase
        end
    end

    // Lane extraction uses the latched address and funct3 since inputs are ignored while BUSY.
    always_comb begin
        w_ld_byte = 8'h0;
        w_ld_half = r_addr[1] ? dmem.i_dmem_rdata[31:16] : dmem.i_dmem_rdata[15:0];
        w_ld_data = 32'h0;
        case (r_addr[1:0])
            2'b00:   w_ld_byte = dmem.i_dmem_rdata[7:0];
            2'b01:   w_ld_byte = dmem.i_dmem_rdata[15:8];
            2'b10:   w_ld_byte = dmem.i_dmem_rdata[23:16];
            default: w_ld_byte = dmem.i_dmem_rdata[31:24];
        endcase
        if (!r_we) begin
            case (r_inst[14:12])
                3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
                3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
                3'b010:  w_ld_data = dmem.i_dmem_rdata;
                3'b100:  w_ld_data = {24'h0, w_ld_byte};
                3'b101:  w_ld_data = {16'h0, w_ld_half};
                default: w_ld_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_mem_valid && w_is_mem && !w_misalign) begin
                    w_next_state = ST_BUSY;
                    w_stall      = 1'b1;
                end
            end
            ST_BUSY: begin
                if (dmem.i_dmem_ack || w_expire) w_next_state = ST_IDLE;
                else                             w_stall      = 1'b1;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_inst        <= 32'h0;
            r_addr        <= 32'h0;
            r_wdata       <= 32'h0;
            r_pc_add4     <= 32'h0;
            r_bmask       <= 4'h0;
            r_we          <= 1'b0;
            r_wb_sel      <= 2'b00;
            r_rd_wren     <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_inst     <= 32'h0;
            r_wb_pc_add4  <= 32'h0;
            r_wb_alu_data <= 32'h0;
            r_wb_ld_data  <= 32'h0;
            r_wb_wb_sel   <= 2'b00;
            r_wb_rd_wren  <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (!i_mem_valid) begin
                    r_wb_valid   <= 1'b0;
                    r_wb_rd_wren <= 1'b0;
                end else if (!w_is_mem || w_misalign) begin
                    r_wb_valid    <= 1'b1;
                    r_wb_inst     <= i_mem_inst;
                    r_wb_pc_add4  <= i_mem_pc_add4;
                    r_wb_alu_data <= i_mem_alu_data;
                    r_wb_ld_data  <= 32'h0;
                    r_wb_wb_sel   <= i_mem_wb_sel;
                    r_wb_rd_wren  <= i_mem_rd_wren && !w_is_mem;
                    r_misalign    <= w_is_mem;
                end else begin
                    r_inst       <= i_mem_inst;
                    r_addr       <= i_mem_alu_data;
                    r_wdata      <= w_st_wdata;
                    r_pc_add4    <= i_mem_pc_add4;
                    r_bmask      <= w_st_bmask;
                    r_we         <= w_is_store;
                    r_wb_sel     <= i_mem_wb_sel;
                    r_rd_wren    <= i_mem_rd_wren;
                    r_wb_valid   <= 1'b0;
                    r_wb_rd_wren <= 1'b0;
                end
            end else if (dmem.i_dmem_ack || w_expire) begin
                // An ack in the expiry cycle takes priority and completes normally.
                r_wb_valid    <= 1'b1;
                r_wb_inst     <= r_inst;
                r_wb_pc_add4  <= r_pc_add4;
                r_wb_alu_data <= r_addr;
                r_wb_ld_data  <= dmem.i_dmem_ack ? w_ld_data : 32'h0;
                r_wb_wb_sel   <= r_wb_sel;
                r_wb_rd_wren  <= dmem.i_dmem_ack ? r_rd_wren : 1'b0;
            end else begin
                r_wb_valid   <= 1'b0;
                r_wb_rd_wren <= 1'b0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_busy_cnt;
    logic          r_fault;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_fault <= w_expire;
            if (r_state == ST_IDLE) r_busy_cnt <= '0;
            else                    r_busy_cnt <= r_busy_cnt + 1'b1;
        end
    end

    assign w_expire    = (r_state == ST_BUSY) && !dmem.i_dmem_ack &&
                         (r_busy_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign o_mem_fault = r_fault;
`else
    assign w_expire    = 1'b0;
    assign o_mem_fault = 1'b0;
`endif

    assign o_mem_stall        = w_stall;
    assign o_mem_misalign     = r_misalign;
    assign o_mem_rd_addr      = i_mem_inst[11:7];
    assign o_dbg_state        = r_state;

    assign dmem.o_dmem_req    = (r_state == ST_BUSY);
    assign dmem.o_dmem_we     = (r_state == ST_BUSY) && r_we;
    assign dmem.o_dmem_addr   = (r_state == ST_BUSY) ? {r_addr[31:2], 2'b00} : 32'h0;
    assign dmem.o_dmem_wdata  = (r_state == ST_BUSY) ? r_wdata : 32'h0;
    assign dmem.o_dmem_bmask  = (r_state == ST_BUSY) ? r_bmask : 4'h0;

    assign o_wb_valid    = r_wb_valid;
    assign o_wb_inst     = r_wb_inst;
    assign o_wb_pc_add4  = r_wb_pc_add4;
    assign o_wb_alu_data = r_wb_alu_data;
    assign o_wb_ld_data  = r_wb_ld_data;
    assign o_wb_wb_sel   = r_wb_wb_sel;
    assign o_wb_rd_wren  = r_wb_rd_wren;

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
MEM pipeline stage of the 5-stage RV32I core. It sits between the EX/MEM boundary and writeback_cycle. It issues loads and stores to a variable-latency data memory through a req/ack handshake, and stalls upstream while an access is outstanding. It extracts and sign- or zero-extends load data. It also registers the MEM/WB pipeline fields that writeback_cycle consumes.

Parameters:
TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_mem_valid  in  1  EX/MEM slot holds a live instruction
i_mem_inst  in  32  instruction word
i_mem_pc_add4  in  32  PC+4
i_mem_alu_data  in  32  ALU result; effective address for loads/stores
i_mem_rs2_data  in  32  store data
i_mem_wb_sel  in  2  writeback select, passed through
i_mem_rd_wren  in  1  register write enable, passed through
o_mem_stall  out  1  hold EX/MEM and earlier stages
o_mem_misalign  out  1  one-cycle pulse on a misaligned access
o_mem_fault  out  1  one-cycle pulse on timeout (0 when MEM_TIMEOUT_EN is undefined)
o_dmem_req  out  1  bus request
o_dmem_we  out  1  1 = store
o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
o_dmem_wdata  out  32  lane-shifted store data
o_dmem_bmask  out  4  byte enables
i_dmem_ack  in  1  access complete; rdata valid in the same cycle
i_dmem_rdata  in  32  read word
o_wb_valid  out  1  MEM/WB slot valid
o_wb_inst  out  32  to writeback_cycle
o_wb_pc_add4  out  32
o_wb_alu_data  out  32
o_wb_ld_data  out  32  extended load result
o_wb_wb_sel  out  2
o_wb_rd_wren  out  1  forced 0 when o_wb_valid=0
o_mem_rd_addr  out  5  i_mem_inst[11:7], combinational, for forwarding

Behaviour:
- Memory op decode:
  - Load: opcode 0000011, funct3 000/001/010/100/101 = LB/LH/LW/LBU/LHU.
  - Store: opcode 0100011, funct3 000/001/010 = SB/SH/SW.
  - Any other funct3 with these opcodes is treated as a non-memory op.
- Misaligned: word access with addr[1:0]!=0; half access with addr[0]!=0.
- FSM has two states, IDLE and BUSY. Reset puts the FSM in IDLE.
- Reset values: all o_wb_* = 0, o_dmem_* = 0, and pulses = 0.
- IDLE with i_mem_valid=0:
  - o_wb_valid<=0 and o_wb_rd_wren<=0 (bubble).
  - o_mem_stall=0.
- IDLE, valid non-memory op:
  - MEM/WB fields <= inputs; o_wb_valid<=1; o_wb_ld_data<=0.
  - Latency 1 cycle; no stall.
- IDLE, valid misaligned memory op:
  - No bus transaction.
  - Fields are passed through with o_wb_rd_wren<=0; o_wb_valid<=1.
  - o_mem_misalign pulses 1 in the cycle after detection (registered).
- IDLE, valid aligned memory op:
  - Latch inst, addr, store data, wb_sel, rd_wren, pc_add4.
  - Go to BUSY; o_mem_stall=1 combinationally; o_wb_valid<=0.
- BUSY: o_dmem_req=1. o_dmem_we, addr, wdata and bmask come from the latched registers and stay stable until ack. Inputs are ignored.
  - i_dmem_ack=0: o_mem_stall=1; o_wb_valid<=0.
  - i_dmem_ack=1: o_mem_stall=0; MEM/WB fields <= latched values, with o_wb_ld_data computed from i_dmem_rdata; o_wb_valid<=1; next state IDLE; req drops the next cycle.
- Minimum load/store latency is 2 cycles (issue plus ack cycle). Each ack-less BUSY cycle adds one.
- Store lanes (o_dmem_bmask / o_dmem_wdata):
  - SB: bmask = 1<<addr[1:0]; wdata = rs2[7:0] replicated to all 4 bytes.
  - SH: bmask = 0011 or 1100 by addr[1]; wdata = rs2[15:0] replicated to both halves.
  - SW: bmask = 1111; wdata = rs2.
- Loads drive bmask=1111 and we=0.
- Load extraction: select the byte or half by addr[1:0] from rdata. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
- Stores complete with the passed-through i_mem_rd_wren. EX decode guarantees it is 0.
- Reset during BUSY: state -> IDLE, req drops the next cycle, the transaction is abandoned, and no MEM/WB write occurs.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a BUSY cycle counter is cleared on entering BUSY. When it reaches TIMEOUT_CYCLES without ack:
  - req drops, FSM returns to IDLE, o_mem_stall=0.
  - MEM/WB completes with o_wb_rd_wren=0 and o_wb_ld_data=0.
  - o_mem_fault pulses 1.
  - An ack arriving in the same cycle as expiry wins.
- Undefined: BUSY waits indefinitely for ack; o_mem_fault is tied to 0; no counter is synthesized.

Test Plan:
- ADDI x5 (inst 0x00A00293), alu_data=0xA -> next cycle o_wb_valid=1, o_wb_alu_data=0xA, o_wb_rd_wren=1, stall never asserted.
- LB x1, addr=0x1003, ack after 3 BUSY cycles, rdata=0x80FFFFFF -> stall high for 3 cycles then low in the ack cycle; o_dmem_addr=0x1000; o_wb_ld_data=0xFFFFFF80; LBU with the same data gives 0x00000080.
- SH addr=0x2002, rs2=0x1234ABCD, immediate ack -> o_dmem_we=1, bmask=1100, wdata=0xABCDABCD, req asserted exactly 1 cycle.
- LW addr=0x3001 -> o_dmem_req stays 0; o_mem_misalign pulse; o_wb_valid=1 with o_wb_rd_wren=0.
- LW issued, i_reset asserted in the second BUSY cycle -> next cycle req=0, state IDLE, o_wb_valid=0; a following ADDI completes normally.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> req drops after 4 BUSY cycles; o_mem_fault pulses 1; o_wb_rd_wren=0; stall released.
